rst_seq_ctrl: RTL and testbench

- Power-up and software-reset sequencer for downstream reset domains.
- Holds all N_STAGE domain resets asserted, then releases them one at a time in index order (0 first).
- Before releasing the next stage, waits for the current stage's ready/init-done with a timeout.
- Sits behind the board clock/reset wrapper, on clk50m, and drives the per-subsystem active-low resets.

---
 rtl/rst_seq_ctrl_if.sv | 24 ++
 rtl/rst_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Bundle between the reset sequencer and its surroundings: restart request,
// per-stage ready inputs, per-stage resets and status outputs.
interface rst_seq_ctrl_if #(
  parameter int N_STAGE = 4,
  parameter int STG_W   = 2
);
  logic               sw_rst_req_i;
  logic [N_STAGE-1:0] stage_rdy_i;
  logic [N_STAGE-1:0] rst_n_o;
  logic               seq_done_o;
  logic               seq_err_o;
  logic [STG_W-1:0]   err_stage_o;
  logic [2:0]         state_o;

  modport master (
    output sw_rst_req_i, stage_rdy_i,
    input  rst_n_o, seq_done_o, seq_err_o, err_stage_o, state_o
  );

  modport slave (
    input  sw_rst_req_i, stage_rdy_i,
    output rst_n_o, seq_done_o, seq_err_o, err_stage_o, state_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Power-up / software-restart reset sequencer: holds every domain in reset,
// then releases them in index order, each gated on the previous one's ready.
module rst_seq_sync (
  input  logic clk50m,
  input  logic hw_arst_n_o,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk50m or negedge hw_arst_n_o) begin
    if (!hw_arst_n_o) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

module rst_seq_ctrl #(
  parameter int N_STAGE  = 4,
  parameter int HOLD_CYC = 1000,
  parameter int GAP_CYC  = 500,
  parameter int TMO_CYC  = 50000,
  parameter int CNT_W    = 16,
  parameter int STG_W    = 2
) (
  input logic           clk50m,
  input logic           hw_arst_n_o,
  rst_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RELEASE = 3'd1,
    S_WAIT    = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [STG_W-1:0] LAST_STG  = STG_W'(N_STAGE - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [STG_W-1:0]   k_q, k_d;
  logic [N_STAGE-1:0] rst_n_q, rst_n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [STG_W-1:0]   err_stg_q, err_stg_d;
  logic [N_STAGE-1:0] rdy_s;
  logic [N_STAGE-1:0] stage_bit;
  logic               rdy_cur;
  logic               restart;

  for (genvar i = 0; i < N_STAGE; i++) begin : g_sync
    rst_seq_sync u_sync (
      .clk50m      (clk50m),
      .hw_arst_n_o (hw_arst_n_o),
      .d_i         (bus.stage_rdy_i[i]),
      .q_o         (rdy_s[i])
    );
  end

  // A restart request while already holding must not stretch the hold window.
  assign restart   = bus.sw_rst_req_i && (state_q != S_HOLD);
  assign rdy_cur   = rdy_s[k_q];
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign stage_bit = N_STAGE'(1) << k_q;

  always_ff @(posedge clk50m or negedge hw_arst_n_o) begin
    if (!hw_arst_n_o) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      k_q       <= '0;
      rst_n_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_stg_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_stg_q <= err_stg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_HOLD:    if (cnt_q == HOLD_LAST) state_d = S_RELEASE;
        S_RELEASE: state_d = S_WAIT;
        // Ready is tested before the timeout so a same-cycle arrival still counts.
        S_WAIT: begin
          if (rdy_cur)                state_d = (k_q == LAST_STG) ? S_DONE : S_GAP;
          else if (cnt_q == TMO_LAST) state_d = S_ERROR;
        end
        S_GAP:     if (cnt_q == GAP_LAST) state_d = S_RELEASE;
        S_DONE:    state_d = S_DONE;
        S_ERROR:   state_d = S_ERROR;
        default:   state_d = S_HOLD;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    k_d       = k_q;
    rst_n_d   = rst_n_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_stg_d = err_stg_q;
    if (restart) begin
      cnt_d     = '0;
      k_d       = '0;
      rst_n_d   = '0;
      err_d     = 1'b0;
      err_stg_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          rst_n_d = '0;
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            k_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_RELEASE: begin
          rst_n_d = rst_n_q | stage_bit;
          cnt_d   = '0;
        end
        S_WAIT: begin
          cnt_d = cnt_inc;
          if (rdy_cur) begin
            cnt_d = '0;
          end else if (cnt_q == TMO_LAST) begin
            err_d     = 1'b1;
            err_stg_d = k_q;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            k_d   = k_q + STG_W'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DONE: begin
          rst_n_d = '1;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rst_n_o     = rst_n_q;
  assign bus.seq_done_o  = done_q;
  assign bus.seq_err_o   = err_q;
  assign bus.err_stage_o = err_stg_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expectations are queued with the cycle they
// are due and checked on the falling edge when that cycle arrives.
module tb_rst_seq_ctrl;
  logic clk50m = 1'b0;
  logic hw_arst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] rst_n;
    logic       done;
    logic       err;
    logic [1:0] stg;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];

  rst_seq_ctrl_if #(.N_STAGE(4), .STG_W(2)) bus ();

  rst_seq_ctrl #(
    .N_STAGE(4), .HOLD_CYC(8), .GAP_CYC(4), .TMO_CYC(20), .CNT_W(8), .STG_W(2)
  ) dut (
    .clk50m      (clk50m),
    .hw_arst_n_o (hw_arst_n),
    .bus         (bus.slave)
  );

  always #10 clk50m = ~clk50m;
  always @(posedge clk50m) cyc <= cyc + 1;

  task automatic push_exp(input int c, input string tag, input logic [3:0] r,
                          input logic d, input logic e, input logic [1:0] s,
                          input logic [2:0] st);
    exp_t x;
    x.cyc = c; x.tag = tag; x.rst_n = r; x.done = d; x.err = e; x.stg = s; x.st = st;
    sb.push_back(x);
  endtask

  task automatic check(input exp_t e);
    n_chk++;
    assert ({bus.rst_n_o, bus.seq_done_o, bus.seq_err_o, bus.err_stage_o, bus.state_o}
            === {e.rst_n, e.done, e.err, e.stg, e.st})
      n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: got rst_n=%b done=%b err=%b stg=%0d st=%0d, want rst_n=%b done=%b err=%b stg=%0d st=%0d",
             e.tag, e.cyc, bus.rst_n_o, bus.seq_done_o, bus.seq_err_o, bus.err_stage_o,
             bus.state_o, e.rst_n, e.done, e.err, e.stg, e.st);
    end
  endtask

  always @(negedge clk50m) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end
    end
  end

  // Returns 1 time unit after the c-th rising edge.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk50m);
      #1;
    end
  endtask

  task automatic sw_pulse();
    bus.sw_rst_req_i = 1'b1;
    wait_until(cyc + 1);
    bus.sw_rst_req_i = 1'b0;
  endtask

  // HOLD is 8 cycles, each stage readies 5 cycles after release, 2-flop
  // sync + 1 decision cycle, GAP 4 cycles, RELEASE 1 cycle: 13-cycle stride.
  task automatic normal_seq(input int b, input string tag);
    push_exp(b + 8,  {tag, "_hold_end"}, 4'b0000, 0, 0, 2'd0, 3'd1);
    push_exp(b + 9,  {tag, "_rel0"},     4'b0001, 0, 0, 2'd0, 3'd2);
    push_exp(b + 21, {tag, "_gap_end"},  4'b0001, 0, 0, 2'd0, 3'd1);
    push_exp(b + 22, {tag, "_rel1"},     4'b0011, 0, 0, 2'd0, 3'd2);
    push_exp(b + 35, {tag, "_rel2"},     4'b0111, 0, 0, 2'd0, 3'd2);
    push_exp(b + 48, {tag, "_rel3"},     4'b1111, 0, 0, 2'd0, 3'd2);
    push_exp(b + 56, {tag, "_done_ent"}, 4'b1111, 0, 0, 2'd0, 3'd4);
    push_exp(b + 57, {tag, "_done"},     4'b1111, 1, 0, 2'd0, 3'd4);
    wait_until(b + 14); bus.stage_rdy_i[0] = 1'b1;
    wait_until(b + 27); bus.stage_rdy_i[1] = 1'b1;
    wait_until(b + 40); bus.stage_rdy_i[2] = 1'b1;
    wait_until(b + 53); bus.stage_rdy_i[3] = 1'b1;
    wait_until(b + 57);
  endtask

  initial begin
    int b;
    int b2;
    hw_arst_n        = 1'b0;
    bus.sw_rst_req_i = 1'b0;
    bus.stage_rdy_i  = '0;

    push_exp(3, "reset_vals", 4'b0000, 0, 0, 2'd0, 3'd0);
    wait_until(5);
    hw_arst_n = 1'b1;
    normal_seq(5, "norm");

    // Ready dropping in DONE must not disturb the outputs.
    wait_until(65);
    bus.stage_rdy_i = '0;
    push_exp(70, "done_sticky", 4'b1111, 1, 0, 2'd0, 3'd4);
    wait_until(70);

    // Stage 2 never reports ready.
    sw_pulse();
    b = cyc;
    push_exp(b,      "restart_from_done", 4'b0000, 0, 0, 2'd0, 3'd0);
    push_exp(b + 35, "tmo_rel2",          4'b0111, 0, 0, 2'd0, 3'd2);
    push_exp(b + 54, "tmo_not_yet",       4'b0111, 0, 0, 2'd0, 3'd2);
    push_exp(b + 55, "tmo_err",           4'b0111, 0, 1, 2'd2, 3'd5);
    push_exp(b + 60, "tmo_err_sticky",    4'b0111, 0, 1, 2'd2, 3'd5);
    wait_until(b + 14); bus.stage_rdy_i[0] = 1'b1;
    wait_until(b + 27); bus.stage_rdy_i[1] = 1'b1;
    wait_until(b + 60);

    // Restart from ERROR; stage 1 ready lands exactly on the timeout cycle.
    bus.stage_rdy_i = '0;
    sw_pulse();
    b = cyc;
    push_exp(b,      "restart_from_err", 4'b0000, 0, 0, 2'd0, 3'd0);
    push_exp(b + 41, "edge_wait",        4'b0011, 0, 0, 2'd0, 3'd2);
    push_exp(b + 42, "edge_gap",         4'b0011, 0, 0, 2'd0, 3'd3);
    push_exp(b + 46, "edge_gap_end",     4'b0011, 0, 0, 2'd0, 3'd1);
    push_exp(b + 47, "edge_rel2",        4'b0111, 0, 0, 2'd0, 3'd2);
    push_exp(b + 60, "edge_rel3",        4'b1111, 0, 0, 2'd0, 3'd2);
    push_exp(b + 69, "edge_done",        4'b1111, 1, 0, 2'd0, 3'd4);
    wait_until(b + 14); bus.stage_rdy_i[0] = 1'b1;
    wait_until(b + 39); bus.stage_rdy_i[1] = 1'b1;
    wait_until(b + 52); bus.stage_rdy_i[2] = 1'b1;
    wait_until(b + 65); bus.stage_rdy_i[3] = 1'b1;
    wait_until(b + 69);

    // Restart while in GAP after stage 0, then a second request inside HOLD.
    bus.stage_rdy_i = '0;
    sw_pulse();
    b = cyc;
    push_exp(b,      "restart3", 4'b0000, 0, 0, 2'd0, 3'd0);
    push_exp(b + 17, "gap0",     4'b0001, 0, 0, 2'd0, 3'd3);
    wait_until(b + 14); bus.stage_rdy_i[0] = 1'b1;
    wait_until(b + 18);
    sw_pulse();
    bus.stage_rdy_i = '0;
    b2 = cyc;
    push_exp(b2,      "gap_restart",   4'b0000, 0, 0, 2'd0, 3'd0);
    push_exp(b2 + 8,  "hold_ignore",   4'b0000, 0, 0, 2'd0, 3'd1);
    push_exp(b2 + 9,  "hold_rel0",     4'b0001, 0, 0, 2'd0, 3'd2);
    push_exp(b2 + 48, "pre_arst_rel3", 4'b1111, 0, 0, 2'd0, 3'd2);
    wait_until(b2 + 3);
    sw_pulse();
    wait_until(b2 + 14); bus.stage_rdy_i[0] = 1'b1;
    wait_until(b2 + 27); bus.stage_rdy_i[1] = 1'b1;
    wait_until(b2 + 40); bus.stage_rdy_i[2] = 1'b1;

    // Hardware reset mid-cycle while waiting on stage 3.
    wait_until(b2 + 50);
    #1;
    hw_arst_n       = 1'b0;
    bus.stage_rdy_i = '0;
    push_exp(b2 + 50, "arst_async", 4'b0000, 0, 0, 2'd0, 3'd0);
    wait_until(b2 + 53);
    hw_arst_n = 1'b1;
    normal_seq(b2 + 53, "post_arst");

    wait_until(cyc + 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
